// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, IF/ID capture register and valid/ready
// delivery to decode, with redirect flush, stall hold, halt and misalignment trapping.
module fetch_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] pc_out,
    input  logic [31:0]      instr_in,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [31:0]      id_instr,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_plus4,
    output logic             halted,
    output logic             misaligned,
    output logic [31:0]      fetch_count
);

    localparam logic [31:0]      NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0]      HALT_INSTR = 32'h0000_006F;
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(32'd4);

    logic [WIDTH-1:0] pc_r, pc_s;
    logic             id_valid_r, id_valid_s;
    logic [31:0]      id_instr_r, id_instr_s;
    logic [WIDTH-1:0] id_pc_r, id_pc_s;
    logic [WIDTH-1:0] id_pc_plus4_r, id_pc_plus4_s;
    logic             halted_r, halted_s;
    logic             misaligned_r, misaligned_s;
    logic [31:0]      fetch_count_r, fetch_count_s;

    logic             handshake_s;
    logic             stall_s;
    logic             stop_s;
    logic             target_misaligned_s;

    // Next-state selection in priority order: stop, misaligned redirect, redirect, stall, capture.
    always_comb begin
        pc_s          = pc_r;
        id_valid_s    = id_valid_r;
        id_instr_s    = id_instr_r;
        id_pc_s       = id_pc_r;
        id_pc_plus4_s = id_pc_plus4_r;
        halted_s      = halted_r;
        misaligned_s  = misaligned_r;
        fetch_count_s = fetch_count_r;

        handshake_s         = id_valid_r && id_ready;
        stall_s             = id_valid_r && !id_ready;
        stop_s              = halted_r || misaligned_r;
        target_misaligned_s = (redirect_target[1:0] != 2'b00);

        if (handshake_s) begin
            fetch_count_s = fetch_count_r + 32'd1;
        end else begin
            fetch_count_s = fetch_count_r;
        end

        if (stop_s) begin
            // A halted/trapped stage only drains the entry already in IF/ID.
            if (handshake_s) begin
                id_valid_s = 1'b0;
            end else begin
                id_valid_s = id_valid_r;
            end
        end else if (redirect_valid && target_misaligned_s) begin
            misaligned_s = 1'b1;
            id_valid_s   = 1'b0;
        end else if (redirect_valid) begin
            pc_s       = redirect_target;
            id_valid_s = 1'b0;
        end else if (stall_s) begin
            id_valid_s = id_valid_r;
        end else begin
            id_instr_s    = instr_in;
            id_pc_s       = pc_r;
            id_pc_plus4_s = pc_r + PC_STEP;
            id_valid_s    = 1'b1;
            // The self-loop parks the PC so it is captured exactly once.
            if (instr_in == HALT_INSTR) begin
                halted_s = 1'b1;
            end else begin
                pc_s = pc_r + PC_STEP;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            id_valid_r    <= 1'b0;
            id_instr_r    <= NOP_INSTR;
            id_pc_r       <= '0;
            id_pc_plus4_r <= '0;
            halted_r      <= 1'b0;
            misaligned_r  <= 1'b0;
            fetch_count_r <= 32'd0;
        end else begin
            pc_r          <= pc_s;
            id_valid_r    <= id_valid_s;
            id_instr_r    <= id_instr_s;
            id_pc_r       <= id_pc_s;
            id_pc_plus4_r <= id_pc_plus4_s;
            halted_r      <= halted_s;
            misaligned_r  <= misaligned_s;
            fetch_count_r <= fetch_count_s;
        end
    end

    assign pc_out      = pc_r;
    assign id_valid    = id_valid_r;
    assign id_instr    = id_instr_r;
    assign id_pc       = id_pc_r;
    assign id_pc_plus4 = id_pc_plus4_r;
    assign halted      = halted_r;
    assign misaligned  = misaligned_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed program walk, random traffic against a
// queue-based reference model, and a second instance exercising PC wrap-around.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];
    assign instr_in = mem[pc_out[7:2]];

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .instr_in(instr_in),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .halted(halted),
        .misaligned(misaligned), .fetch_count(fetch_count)
    );

    logic        w_rst_n;
    logic [31:0] w_pc_out;
    logic [31:0] w_instr;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_target;
    logic        w_id_ready;
    logic        w_id_valid;
    logic [31:0] w_id_instr;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_pc_plus4;
    logic        w_halted;
    logic        w_misaligned;
    logic [31:0] w_fetch_count;

    fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .pc_out(w_pc_out), .instr_in(w_instr),
        .redirect_valid(w_redirect_valid), .redirect_target(w_redirect_target),
        .id_ready(w_id_ready), .id_valid(w_id_valid), .id_instr(w_id_instr),
        .id_pc(w_id_pc), .id_pc_plus4(w_id_pc_plus4), .halted(w_halted),
        .misaligned(w_misaligned), .fetch_count(w_fetch_count)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      exp_q[$];
    entry_t      mon_e;
    logic        mon_en = 1'b0;

    // Reference state: what the stage should hold after each edge.
    logic [31:0] m_pc = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_count = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rn, input logic rdy, input logic rv, input logic [31:0] tgt);
        logic        hs;
        logic [31:0] w;
        hs = m_valid && rdy;
        if (!rn) begin
            m_pc = 32'd0; m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0; m_count = 32'd0;
            exp_q.delete();
        end else begin
            if (hs) m_count = m_count + 32'd1;
            if (m_halted || m_mis) begin
                if (hs) m_valid = 1'b0;
            end else if (rv && (tgt % 32'd4 != 32'd0)) begin
                m_mis = 1'b1; m_valid = 1'b0; exp_q.delete();
            end else if (rv) begin
                m_pc = tgt; m_valid = 1'b0; exp_q.delete();
            end else if (m_valid && !rdy) begin
                m_valid = 1'b1;
            end else begin
                w = mem[(m_pc / 32'd4) % 32'd64];
                exp_q.push_back('{instr: w, pc: m_pc});
                m_valid = 1'b1;
                if (w == 32'h0000_006F) m_halted = 1'b1;
                else m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input logic rn, input logic rdy, input logic rv, input logic [31:0] tgt);
        rst_n = rn; id_ready = rdy; redirect_valid = rv; redirect_target = tgt;
        @(posedge clk);
        #1;
        model_edge(rn, rdy, rv, tgt);
    endtask

    // Monitor: compare architectural state, and pop the scoreboard on every handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("pc_out", pc_out, m_pc);
            chk("id_valid", 32'(id_valid), 32'(m_valid));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("misaligned", 32'(misaligned), 32'(m_mis));
            chk("fetch_count", fetch_count, m_count);
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake: got id_pc %h with no expected entry at %0t", id_pc, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("hs_id_instr", id_instr, mon_e.instr);
                    chk("hs_id_pc", id_pc, mon_e.pc);
                    chk("hs_id_pc_plus4", id_pc_plus4, mon_e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        logic        rn, rdy, rv;
        logic [31:0] tgt, w;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h00C0_0413; mem[1] = 32'h0090_0493; mem[2] = 32'h0094_0C63;
        mem[3] = 32'h0084_C663; mem[4] = 32'h4094_0433; mem[5] = 32'hFF5F_F06F;
        mem[6] = 32'h4084_84B3; mem[7] = 32'hFEDF_F06F; mem[8] = 32'h0000_006F;

        rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0;

        // Wrap-around instance.
        w_rst_n = 1'b0; w_instr = 32'h0000_0013; w_id_ready = 1'b1;
        w_redirect_valid = 1'b0; w_redirect_target = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("wrap_reset_pc", w_pc_out, 32'hFFFF_FFFC);
        w_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("wrap_id_valid", 32'(w_id_valid), 32'd1);
        chk("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_pc_plus4", w_id_pc_plus4, 32'h0000_0000);
        chk("wrap_pc_out", w_pc_out, 32'h0000_0000);

        // Reset and first fetch.
        step(1'b0, 1'b1, 1'b0, 32'd0);
        mon_en = 1'b1;
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("first_id_valid", 32'(id_valid), 32'd1);
        chk("first_id_instr", id_instr, 32'h00C0_0413);
        chk("first_id_pc_plus4", id_pc_plus4, 32'h4);
        chk("first_pc_out", pc_out, 32'h4);

        // Backpressure.
        step(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("stall_id_instr", id_instr, 32'h0090_0493);
        chk("stall_pc_out", pc_out, 32'h8);
        chk("stall_fetch_count", fetch_count, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("unstall_fetch_count", fetch_count, 32'd2);
        chk("unstall_id_pc", id_pc, 32'h8);

        // Redirect beats stall.
        step(1'b1, 1'b0, 1'b1, 32'h18);
        chk("redir_id_valid", 32'(id_valid), 32'd0);
        chk("redir_pc_out", pc_out, 32'h18);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("redir_id_pc", id_pc, 32'h18);
        chk("redir_id_instr", id_instr, 32'h4084_84B3);

        // Halt on the self-loop.
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("halt_id_instr", id_instr, 32'h0000_006F);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc_out", pc_out, 32'h20);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("halt_drained", 32'(id_valid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h20);
        step(1'b1, 1'b1, 1'b1, 32'h04);
        chk("halt_ignore_valid", 32'(id_valid), 32'd0);
        chk("halt_ignore_pc", pc_out, 32'h20);
        chk("halt_fetch_count", fetch_count, 32'd5);

        // Misaligned redirect.
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0A);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_id_valid", 32'(id_valid), 32'd0);
        chk("mis_pc_out", pc_out, 32'h4);
        step(1'b1, 1'b1, 1'b1, 32'h0);
        chk("mis_ignore_pc", pc_out, 32'h4);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("mis_cleared", 32'(misaligned), 32'd0);
        chk("mis_reset_pc", pc_out, 32'h0);

        // Random traffic; memory is re-randomized only while reset is applied.
        for (int n = 0; n < 3000; n++) begin
            rn  = !(($urandom_range(0, 99) == 0) || ((m_halted || m_mis) && $urandom_range(0, 7) == 0));
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            tgt = 32'($urandom_range(0, 63)) * 32'd4;
            if ($urandom_range(0, 15) == 0) tgt = tgt + 32'($urandom_range(1, 3));
            if (!rn) begin
                for (int i = 0; i < 64; i++) begin
                    w = $urandom;
                    mem[i] = (w == 32'h0000_006F) ? 32'h0000_0013 : w;
                end
                if ($urandom_range(0, 1) == 1) mem[$urandom_range(4, 63)] = 32'h0000_006F;
            end
            step(rn, rdy, rv, tgt);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the RISC-V core; drives the instruction memory and consumes its instruction word.
- Holds the program counter and captures each fetched word into an IF/ID register.
- Delivers the word to decode over a valid/ready handshake.
- Handles branch/jump redirects, downstream stalls, halt on the self-loop `jal x0 0`, and misaligned-target errors.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- pc_out  out  WIDTH  current PC to instruction memory; equals the PC register.
- instr_in  in  32  instruction word returned combinationally by instruction memory for pc_out.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  WIDTH  new PC when redirect_valid=1.
- id_ready  in  1  decode can accept the IF/ID contents this cycle.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_instr  out  32  fetched instruction.
- id_pc  out  WIDTH  address of id_instr.
- id_pc_plus4  out  WIDTH  id_pc+4, modulo 2^WIDTH.
- halted  out  1  sticky; the self-loop instruction 0x0000006F has been fetched.
- misaligned  out  1  sticky; a redirect target with target[1:0]!=0 was received.
- fetch_count  out  32  number of completed handshakes (id_valid&&id_ready); wraps modulo 2^32.

Behaviour:
- Reset (rst_n=0 at edge) sets: pc=RESET_PC, id_valid=0, id_instr=0x00000013 (NOP), id_pc=0, id_pc_plus4=0, halted=0, misaligned=0, fetch_count=0. Reset overrides all other inputs, including mid-stall or mid-redirect.
- Latency: the word at pc_out in cycle N appears on id_instr/id_pc in cycle N+1.
- Define stall = id_valid && !id_ready, and stop = halted || misaligned.
- Per-edge priority, highest first:
  1. Reset.
  2. If stop=1: redirects are ignored. pc holds. id_valid clears once the current entry handshakes, otherwise id_* hold.
  3. redirect_valid with target[1:0]!=0: misaligned<=1, id_valid<=0, pc unchanged.
  4. redirect_valid with an aligned target: pc<=redirect_target, id_valid<=0 (flush). This applies even when stall=1; redirect beats stall.
  5. stall: pc and all id_* hold, stable and unchanged.
  6. Otherwise, capture: id_instr<=instr_in, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1.
     - If instr_in==0x0000006F: halted<=1 and pc holds.
     - Else pc<=pc+4, wrapping modulo 2^WIDTH.
- Halt instruction: delivered to decode exactly once, then no further captures.
- fetch_count increments on any edge where id_valid && id_ready were both 1 before the edge, regardless of redirect.
- Handshake rules:
  - Once id_valid=1, id_* must not change until the handshake completes, except by redirect flush or reset.
  - id_valid never deasserts without a handshake except by flush or reset.
- Arithmetic: all PC adds are unsigned WIDTH-bit with no carry out. 0xFFFFFFFC+4 = 0x00000000.
- No combinational path from id_ready or redirect_* to any output. pc_out depends only on registers.

Test Plan:
- Reset/first fetch (memory holds the GCD program: 0x00C00413 at 0x00, 0x00900493 at 0x04, ...). Hold rst_n=0 for 2 cycles -> pc_out=0x00, id_valid=0, id_instr=0x00000013. Release with id_ready=1 -> next cycle id_valid=1, id_pc=0x00, id_instr=0x00C00413, id_pc_plus4=0x04, pc_out=0x04.
- Backpressure: id_ready=0 for 3 cycles while id_pc=0x04 -> id_instr stays 0x00900493, pc_out stays 0x08, fetch_count unchanged. Raise id_ready -> fetch_count+1, next id_pc=0x08.
- Redirect during stall: redirect_valid=1, target=0x18 with id_ready=0 -> next cycle id_valid=0, pc_out=0x18. Following cycle id_valid=1, id_pc=0x18, id_instr=0x408484B3.
- Halt: sequential fetch reaches 0x20 -> id_instr=0x0000006F delivered once, halted=1, pc_out stays 0x20. After the handshake id_valid=0 permanently. A redirect to 0x20 has no effect.
- Misaligned: redirect target 0x0A -> misaligned=1, id_valid=0, pc_out unchanged. A later aligned redirect to 0x00 is ignored. Pulse rst_n -> misaligned=0, pc_out=RESET_PC.
- Wrap: RESET_PC=0xFFFFFFFC, instr_in=0x00000013 -> first capture id_pc=0xFFFFFFFC, id_pc_plus4=0x00000000, pc_out=0x00000000.
